// File: rtl/tt_um_ring_osc_meter.sv
`timescale 1ns/1ps
// tt_um_ring_osc_meter: gated ring oscillator plus a frequency meter.
// The ring runs in its own domain. A ripple prescaler divides it down.
// The divided signal is synchronised into clk and its rising edges are
// counted over a gate window of 2^(8+win) clk cycles.
module tt_um_ring_osc_meter #(
    parameter int STEP          = 4,
    parameter int PRESCALE_BITS = 4,
    parameter int COUNT_W       = 16,
    parameter int SETTLE        = 16,
    parameter int INV_DELAY     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int N_INV = 8 * STEP;   // inverters in the longest ring
    localparam int TW    = 16;         // phase timer width (gate up to 32768)

    typedef enum logic [2:0] {IDLE, ARM, GATE, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic                 ring_en_q, ring_en_d;
    logic [1:0]           sel_q, sel_d;
    logic [2:0]           win_q, win_d;
    logic                 cont_q, cont_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;
    logic [COUNT_W-1:0]   res_q, res_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;
    logic                 st_s1_q, st_s2_q, st_s3_q;
    logic                 ms_s1_q, ms_s2_q, ms_s3_q;

    // ---------------------------------------------------------------
    // Ring: NAND (enable gate) followed by N_INV inverters. The delays
    // only give the loop a period in simulation; synthesis drops them.
    // ---------------------------------------------------------------
    logic       nand_o;
    logic       ring_out;
    logic [3:0] taps;

    assign #INV_DELAY nand_o = ~(ring_en_q & ring_out);

    for (genvar i = 0; i < N_INV; i++) begin : g_inv
        logic inv_o;
        if (i == 0) begin : g_first
            assign #INV_DELAY inv_o = ~nand_o;
        end else begin : g_rest
            assign #INV_DELAY inv_o = ~g_inv[i-1].inv_o;
        end
    end

    // Tap s sits after 2*STEP*(s+1) inverters; even count keeps the loop odd.
    for (genvar s = 0; s < 4; s++) begin : g_tap
        assign taps[s] = g_inv[2*STEP*(s+1)-1].inv_o;
    end

    assign ring_out = taps[sel_q];

    // ---------------------------------------------------------------
    // Ripple prescaler: each stage toggles on the falling edge of the
    // previous one, so it holds its value whenever the ring is stopped.
    // ---------------------------------------------------------------
    logic [PRESCALE_BITS-1:0] pre;

    for (genvar i = 0; i < PRESCALE_BITS; i++) begin : g_pre
        logic t_q;
        if (i == 0) begin : g_first
            // first divider stage, clocked by the ring itself
            always_ff @(posedge ring_out or negedge rst_n)
                if (!rst_n) t_q <= 1'b0;
                else        t_q <= ~t_q;
        end else begin : g_rest
            // later stages ripple off the previous stage
            always_ff @(negedge pre[i-1] or negedge rst_n)
                if (!rst_n) t_q <= 1'b0;
                else        t_q <= ~t_q;
        end
        assign pre[i] = t_q;
    end

    // ---------------------------------------------------------------
    // clk domain
    // ---------------------------------------------------------------
    logic          start_rise, meas_rise;
    logic [TW-1:0] gate_last;

    assign start_rise = st_s2_q & ~st_s3_q;
    assign meas_rise  = ms_s2_q & ~ms_s3_q;
    assign gate_last  = TW'((32'd1 << (8 + int'(win_q))) - 32'd1);

    // start and prescaler MSB synchronisers, one extra flop each for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_s1_q <= 1'b0; st_s2_q <= 1'b0; st_s3_q <= 1'b0;
            ms_s1_q <= 1'b0; ms_s2_q <= 1'b0; ms_s3_q <= 1'b0;
        end else begin
            st_s1_q <= ui_in[0]; st_s2_q <= st_s1_q; st_s3_q <= st_s2_q;
            ms_s1_q <= pre[PRESCALE_BITS-1]; ms_s2_q <= ms_s1_q; ms_s3_q <= ms_s2_q;
        end
    end

    // FSM state and measurement registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ring_en_q <= 1'b0;
            sel_q     <= '0;
            win_q     <= '0;
            cont_q    <= 1'b0;
            tmr_q     <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ring_en_q <= ring_en_d;
            sel_q     <= sel_d;
            win_q     <= win_d;
            cont_q    <= cont_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    // next-state: phase sequencing, edge counting, result capture
    always_comb begin
        logic go_arm;
        go_arm  = 1'b0;
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        done_d  = done_q;
        sel_d   = sel_q;
        win_d   = win_q;
        cont_d  = cont_q;
        case (state_q)
            IDLE: begin
                if (start_rise) go_arm = 1'b1;
            end
            ARM: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == TW'(SETTLE - 1)) begin
                    state_d = GATE;
                    tmr_d   = '0;
                end
            end
            GATE: begin
                tmr_d = tmr_q + 1'b1;
                if (meas_rise) begin
                    if (&cnt_q) ovf_d = 1'b1;
                    else        cnt_d = cnt_q + 1'b1;
                end
                if (tmr_q == gate_last) begin
                    state_d = DRAIN;
                    tmr_d   = '0;
                end
            end
            DRAIN: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == TW'(3)) begin
                    state_d = DONE;
                    res_d   = cnt_q;
                end
            end
            DONE: begin
                done_d = 1'b1;
                if (cont_q) begin
                    go_arm = 1'b1;
                end else if (start_rise) begin
                    go_arm = 1'b1;
                    done_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // config is captured only on the way into ARM
        if (go_arm) begin
            state_d = ARM;
            tmr_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            sel_d   = ui_in[2:1];
            win_d   = ui_in[5:3];
            cont_d  = ui_in[7];
        end
        ring_en_d = (state_d == ARM) || (state_d == GATE);
    end

    // outputs
    logic        busy;
    logic [15:0] res16;

    assign busy    = (state_q == ARM) || (state_q == GATE) || (state_q == DRAIN);
    assign res16   = 16'(res_q);
    assign uo_out  = ui_in[6] ? res16[15:8] : res16[7:0];
    assign uio_out = {4'b0000, ms_s2_q, ovf_q, done_q, busy};
    assign uio_oe  = 8'h0F;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in};

endmodule

// File: tb/tb_tt_um_ring_osc_meter.sv
`timescale 1ns/1ps
// Bench for tt_um_ring_osc_meter: directed measurement table plus
// continuous-mode, mid-run reset and overflow sequences.
module tb_tt_um_ring_osc_meter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in, ui2;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] uo2, uio2, oe2;

    always #5 clk = ~clk;

    tt_um_ring_osc_meter dut (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(8'h00), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    tt_um_ring_osc_meter #(.COUNT_W(9), .PRESCALE_BITS(1)) dut_ovf (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui2), .uo_out(uo2),
        .uio_in(8'h00), .uio_out(uio2), .uio_oe(oe2)
    );

    int checks   = 0;
    int failures = 0;
    int ring_toggles = 0;

    always @(dut.ring_out) ring_toggles++;

    typedef struct {
        int sel;
        int win;
        int lo;
        int hi;
    } vec_t;

    vec_t tbl [6];

    task automatic chk_eq(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // pulse start with the given config and wait for done (bounded)
    task automatic run_meas(input int which, input int sel, input int win, input int cont,
                            output int lat, output int b1, output int b2);
        logic [7:0] cfg;
        logic [7:0] st;
        bit         seen;
        cfg = {cont[0], 1'b0, win[2:0], sel[1:0], 1'b1};
        @(negedge clk);
        if (which == 0) ui_in = cfg; else ui2 = cfg;
        @(posedge clk);
        lat = -1; b1 = -1; b2 = -1; seen = 0;
        for (int c = 1; c <= 40000; c++) begin
            @(posedge clk); #1;
            st = (which == 0) ? uio_out : uio2;
            if (c == 1) b1 = int'(st[0]);
            if (c == 2) b2 = int'(st[0]);
            if (c == 4) begin
                if (which == 0) ui_in[0] = 1'b0; else ui2[0] = 1'b0;
            end
            if (st[0]) seen = 1;
            if (seen && st[1]) begin
                lat = c;
                break;
            end
        end
    endtask

    // read both result bytes through the byte-select mux
    task automatic read_res(input int which, output int lo, output int hi);
        #1;
        if (which == 0) ui_in[6] = 1'b0; else ui2[6] = 1'b0;
        #1;
        lo = (which == 0) ? int'(uo_out) : int'(uo2);
        if (which == 0) ui_in[6] = 1'b1; else ui2[6] = 1'b1;
        #1;
        hi = (which == 0) ? int'(uo_out) : int'(uo2);
        if (which == 0) ui_in[6] = 1'b0; else ui2[6] = 1'b0;
    endtask

    initial begin
        int lat, b1, b2, lo, hi, gap, snap;

        tbl[0] = '{0, 4, 28, 29};   // 90 ns ring, /16 -> 1440 ns
        tbl[1] = '{3, 4,  7,  8};   // 330 ns ring -> 5280 ns
        tbl[2] = '{1, 4, 15, 16};   // 170 ns ring -> 2720 ns
        tbl[3] = '{2, 4, 10, 11};   // 250 ns ring -> 4000 ns
        tbl[4] = '{0, 0,  1,  2};   // 256-cycle window
        tbl[5] = '{0, 2,  7,  8};   // 1024-cycle window

        // reset state
        rst_n = 1'b1; ui_in = 8'h00; ui2 = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_uo_lo", int'(uo_out), 0);
        chk_eq("rst_uio_out", int'(uio_out), 0);
        chk_eq("rst_uio_oe", int'(uio_oe), 8'h0F);
        ui_in[6] = 1'b1; #1;
        chk_eq("rst_uo_hi", int'(uo_out), 0);
        ui_in[6] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // measurement table
        for (int i = 0; i < 6; i++) begin
            run_meas(0, tbl[i].sel, tbl[i].win, 0, lat, b1, b2);
            chk_eq($sformatf("v%0d_latency", i), lat, 23 + (1 << (8 + tbl[i].win)));
            if (i == 0) begin
                chk_eq("start_busy_n1", b1, 0);
                chk_eq("start_busy_n2", b2, 1);
            end
            chk_eq($sformatf("v%0d_busy_done", i), int'(uio_out[0]), 0);
            chk_eq($sformatf("v%0d_ovf", i), int'(uio_out[2]), 0);
            read_res(0, lo, hi);
            chk_rng($sformatf("v%0d_result", i), lo, tbl[i].lo, tbl[i].hi);
            chk_eq($sformatf("v%0d_hi_byte", i), hi, 0);
            repeat (3) @(posedge clk);
        end

        // continuous mode: one start, then DONE->ARM loops
        run_meas(0, 0, 4, 1, lat, b1, b2);
        chk_eq("cont_latency", lat, 23 + 4096);
        chk_eq("cont_rearm_busy", int'(uio_out[0]), 1);
        read_res(0, lo, hi);
        chk_rng("cont_result0", lo, 28, 29);
        for (int p = 1; p <= 2; p++) begin
            gap = -1;
            for (int c = 1; c <= 5000; c++) begin
                @(posedge clk); #1;
                if (c == 100) ui_in[0] = 1'b1;   // start edge while busy
                if (c == 110) ui_in[0] = 1'b0;
                if (c == 2000) chk_eq("cont_done_held", int'(uio_out[1]), 1);
                if (!uio_out[0]) begin
                    gap = c;
                    break;
                end
            end
            chk_eq($sformatf("cont_period%0d", p), gap, 4116);
            @(posedge clk); #1;
            chk_eq($sformatf("cont_busy_back%0d", p), int'(uio_out[0]), 1);
            chk_eq($sformatf("cont_done%0d", p), int'(uio_out[1]), 1);
            read_res(0, lo, hi);
            chk_rng($sformatf("cont_result%0d", p), lo, 28, 29);
        end

        // mid-run reset during GATE
        repeat (1000) @(posedge clk);
        @(negedge clk);
        ui_in = 8'h00;
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_uio_out", int'(uio_out), 0);
        chk_eq("mid_rst_uo_lo", int'(uo_out), 0);
        #5;
        chk_eq("mid_rst_nand_high", int'(dut.nand_o), 1);
        #200;
        snap = ring_toggles;
        #400;
        chk_eq("mid_rst_ring_static", ring_toggles - snap, 0);
        ui_in[6] = 1'b1; #1;
        chk_eq("mid_rst_uo_hi", int'(uo_out), 0);
        ui_in[6] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        run_meas(0, 0, 4, 0, lat, b1, b2);
        chk_eq("post_rst_latency", lat, 23 + 4096);
        read_res(0, lo, hi);
        chk_rng("post_rst_result", lo, 28, 29);
        chk_eq("post_rst_ovf", int'(uio_out[2]), 0);

        // overflow: COUNT_W=9, PRESCALE_BITS=1, win=7 (ideal ~1820 edges)
        run_meas(1, 0, 7, 0, lat, b1, b2);
        chk_eq("ovf_latency", lat, 23 + 32768);
        read_res(1, lo, hi);
        chk_eq("ovf_result", hi * 256 + lo, 511);
        chk_eq("ovf_flag", int'(uio2[2]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
